// File: rtl/adsr_gen_p.sv
// rtl/adsr_gen_p.sv - ADSR envelope generator with hold stage, legato/hard retrigger and trigger input.
// Define ADSR_EXP_EN for quasi-exponential DECAY/RELEASE; default build is linear.
module adsr_gen_p #(
    parameter int NBIT_DATA = 6,
    parameter int NBIT_IDX  = 4,
    parameter int MAX_IDX   = 14,
    parameter int STEP_THR0 = 190,
    parameter int CNT_W     = 28
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 vin,
    input  logic                 trig,
    input  logic                 retrig_mode,
    input  logic [NBIT_IDX-1:0]  a_t_idx,
    input  logic [NBIT_IDX-1:0]  h_t_idx,
    input  logic [NBIT_IDX-1:0]  d_t_idx,
    input  logic [NBIT_DATA-1:0] s_level,
    input  logic [NBIT_IDX-1:0]  r_t_idx,
    output logic [NBIT_DATA-1:0] dout,
    output logic                 vout,
    output logic [2:0]           stage,
    output logic                 eoc
);

    localparam logic [NBIT_DATA-1:0] LMAX = '1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ATTACK  = 3'd1,
        S_HOLD    = 3'd2,
        S_DECAY   = 3'd3,
        S_SUSTAIN = 3'd4,
        S_RELEASE = 3'd5
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic                 vin_d;
    logic                 vin_rise;
    logic                 active;
    logic [NBIT_IDX-1:0]  idx_sel;
    logic [NBIT_IDX-1:0]  idx_c;
    logic [CNT_W-1:0]     period;
    logic                 tick;
    logic [NBIT_DATA-1:0] target;
    logic [NBIT_DATA-1:0] dec;
    logic [NBIT_DATA-1:0] dn_lvl;
    logic [NBIT_DATA-1:0] up_lvl;
    logic [NBIT_DATA-1:0] lvl_tick;

    assign stage    = state;
    assign vin_rise = vin & ~vin_d;
    assign active   = (state == S_ATTACK) || (state == S_HOLD) ||
                      (state == S_DECAY)  || (state == S_SUSTAIN);

    always_comb begin
        case (state)
            S_ATTACK:  idx_sel = a_t_idx;
            S_HOLD:    idx_sel = h_t_idx;
            S_DECAY:   idx_sel = d_t_idx;
            S_RELEASE: idx_sel = r_t_idx;
            default:   idx_sel = '0;
        endcase
        idx_c  = (int'(idx_sel) > MAX_IDX) ? NBIT_IDX'(MAX_IDX) : idx_sel;
        period = CNT_W'(STEP_THR0 + 1) << idx_c;
        tick   = (cnt == period - CNT_W'(1));

        up_lvl = (dout == LMAX) ? LMAX : dout + NBIT_DATA'(1);
        target = (state == S_DECAY) ? s_level : '0;
`ifdef ADSR_EXP_EN
        dec    = (dout >> 3) + NBIT_DATA'(1);
`else
        dec    = NBIT_DATA'(1);
`endif
        // Decrement lands exactly on the stage target rather than stepping past it.
        if (dout <= target)
            dn_lvl = dout;
        else if ((dout - target) > dec)
            dn_lvl = dout - dec;
        else
            dn_lvl = target;

        case (state)
            S_ATTACK:           lvl_tick = tick ? up_lvl : dout;
            S_DECAY, S_RELEASE: lvl_tick = tick ? dn_lvl : dout;
            default:            lvl_tick = dout;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= S_IDLE;
            dout  <= '0;
            vout  <= 1'b0;
            eoc   <= 1'b0;
            cnt   <= '0;
            vin_d <= 1'b0;
        end else begin
            vin_d <= vin;
            eoc   <= 1'b0;
            cnt   <= (tick || state == S_IDLE || state == S_SUSTAIN) ? '0 : cnt + CNT_W'(1);
            dout  <= lvl_tick;
            // Gate release outranks any retrigger arriving in the same cycle.
            if (active && !vin) begin
                state <= S_RELEASE;
                cnt   <= '0;
            end else if ((active && trig) || (state == S_RELEASE && vin_rise)) begin
                state <= S_ATTACK;
                cnt   <= '0;
                if (retrig_mode)
                    dout <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        dout <= '0;
                        if (vin_rise) begin
                            state <= S_ATTACK;
                            vout  <= 1'b1;
                            cnt   <= '0;
                        end
                    end
                    S_ATTACK: begin
                        if (tick && up_lvl == LMAX) begin
                            cnt <= '0;
                            if (h_t_idx == '0)
                                state <= (s_level == LMAX) ? S_SUSTAIN : S_DECAY;
                            else
                                state <= S_HOLD;
                        end
                    end
                    S_HOLD: begin
                        if (tick)
                            state <= (s_level == LMAX) ? S_SUSTAIN : S_DECAY;
                    end
                    S_DECAY: begin
                        if (dout <= s_level || (tick && dn_lvl == s_level)) begin
                            state <= S_SUSTAIN;
                            cnt   <= '0;
                        end
                    end
                    S_SUSTAIN: begin
                        state <= S_SUSTAIN;
                    end
                    S_RELEASE: begin
                        if (dout == '0 || (tick && dn_lvl == '0)) begin
                            state <= S_IDLE;
                            vout  <= 1'b0;
                            eoc   <= 1'b1;
                            cnt   <= '0;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        vout  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
